// File: rtl/game_ctrl_pkg.sv
// Shared game package: state encodings and BCD score geometry
// used by the controller, display and collision blocks.
package game_ctrl_pkg;

    localparam int BCD_W   = 4;
    localparam int DIGITS  = 4;
    localparam int SCORE_W = BCD_W * DIGITS;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 16'h9999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DEAD  = 2'b10,
        ST_CLEAR = 2'b11
    } state_e;

endpackage

// File: rtl/game_ctrl_if.sv
// Controller-facing signal bundle: frame timing, collision sampling
// and the game status outputs.
interface game_ctrl_if;
    import game_ctrl_pkg::*;

    logic               start;
    logic               frame_tick;
    logic               pix_crash;
    logic               rdn;
    logic [1:0]         state;
    logic               game_run;
    logic               game_over;
    logic               clr_world;
    logic [SCORE_W-1:0] score_bcd;
    logic [2:0]         speed_level;

    modport master (
        output start, frame_tick, pix_crash, rdn,
        input  state, game_run, game_over, clr_world,
        input  score_bcd, speed_level
    );

    modport slave (
        input  start, frame_tick, pix_crash, rdn,
        output state, game_run, game_over, clr_world,
        output score_bcd, speed_level
    );

endinterface

// File: rtl/game_ctrl_bcd_counter4.sv
// Four-digit BCD score counter, saturating at 9999.
// wrap00 flags an increment whose result ends in 00.
module bcd_counter4
    import game_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               clr,
    output logic [SCORE_W-1:0] q,
    output logic               wrap00
);

    logic [SCORE_W-1:0] q_q;
    logic [SCORE_W-1:0] q_d;
    logic               sat;

    assign sat = (q_q == SCORE_MAX);

    always_comb begin
        logic carry;
        q_d   = q_q;
        carry = 1'b1;
        if (clr) begin
            q_d = '0;
        end else if (inc && !sat) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (carry) begin
                    if (q_q[i*BCD_W +: BCD_W] == BCD_W'(9)) begin
                        q_d[i*BCD_W +: BCD_W] = '0;
                    end else begin
                        q_d[i*BCD_W +: BCD_W] =
                            q_q[i*BCD_W +: BCD_W] + BCD_W'(1);
                        carry = 1'b0;
                    end
                end
            end
        end
    end

    // Saturated 9999 also ends in 99 but does not advance
    assign wrap00 = inc && !clr && !sat &&
                    (q_q[2*BCD_W-1:0] == 8'h99);

    always_ff @(posedge clk) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencing FSM: start/restart, per-frame collision
// evaluation with grace period, score and speed tracking.
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int MAX_LEVEL    = 7,
    parameter int GRACE_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    game_ctrl_if.slave io
);

    localparam int GW =
        (GRACE_FRAMES < 1) ? 1 : $clog2(GRACE_FRAMES + 1);

    state_e             state_q, state_d;
    logic               start_q;
    logic               hit_q, hit_d;
    logic [GW-1:0]      grace_q, grace_d;
    logic [2:0]         speed_q, speed_d;
    logic               run_q, run_d;
    logic               over_q, over_d;
    logic               clrw_q, clrw_d;
    logic               cnt_inc, cnt_clr;
    logic               wrap00;
    logic               start_edge;
    logic               hit_now;
    logic [SCORE_W-1:0] score;

    assign start_edge = io.start && !start_q;
    assign hit_now    = !io.rdn && io.pix_crash;

    always_comb begin
        state_d = state_q;
        hit_d   = hit_q;
        grace_d = grace_q;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DEAD: begin
                // Clear on entry so CLEAR already shows 0000
                if (start_edge) begin
                    state_d = ST_CLEAR;
                    cnt_clr = 1'b1;
                    hit_d   = 1'b0;
                    grace_d = '0;
                end
            end
            ST_CLEAR: begin
                state_d = ST_RUN;
                cnt_clr = 1'b1;
                hit_d   = 1'b0;
                grace_d = '0;
            end
            ST_RUN: begin
                hit_d = hit_q || hit_now;
                if (io.frame_tick) begin
                    if (grace_q < GW'(GRACE_FRAMES)) begin
                        grace_d = grace_q + GW'(1);
                        hit_d   = 1'b0;
                    end else if (hit_q || hit_now) begin
                        state_d = ST_DEAD;
                    end else begin
                        cnt_inc = 1'b1;
                        hit_d   = 1'b0;
                    end
                end
            end
        endcase
    end

    always_comb begin
        speed_d = speed_q;
        if (cnt_clr) begin
            speed_d = '0;
        end else if (wrap00 && speed_q < 3'(MAX_LEVEL)) begin
            speed_d = speed_q + 3'd1;
        end
    end

    always_comb begin
        run_d  = (state_d == ST_RUN);
        over_d = (state_d == ST_DEAD);
        clrw_d = (state_d == ST_CLEAR);
    end

    // Start history loads the live button so reset never fakes an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            start_q <= io.start;
            hit_q   <= 1'b0;
            grace_q <= '0;
            speed_q <= '0;
            run_q   <= 1'b0;
            over_q  <= 1'b0;
            clrw_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= io.start;
            hit_q   <= hit_d;
            grace_q <= grace_d;
            speed_q <= speed_d;
            run_q   <= run_d;
            over_q  <= over_d;
            clrw_q  <= clrw_d;
        end
    end

    bcd_counter4 u_score (
        .clk    (clk),
        .rst    (rst),
        .inc    (cnt_inc),
        .clr    (cnt_clr),
        .q      (score),
        .wrap00 (wrap00)
    );

    assign io.state       = state_q;
    assign io.game_run    = run_q;
    assign io.game_over   = over_q;
    assign io.clr_world   = clrw_q;
    assign io.score_bcd   = score;
    assign io.speed_level = speed_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: stimulus pushes expected status,
// a negedge monitor pops and compares.
module tb_game_ctrl;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DEAD  = 2'd2;
    localparam logic [1:0] S_CLEAR = 2'd3;

    logic clk = 1'b0;
    logic rst;

    game_ctrl_if io ();

    game_ctrl #(
        .MAX_LEVEL    (7),
        .GRACE_FRAMES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    string      nq[$];
    logic [1:0] sq[$];
    logic [15:0] cq[$];
    logic [2:0] pq[$];

    int         m_score;
    int         m_speed;
    int         m_grace;
    logic [1:0] m_st;

    function automatic logic [15:0] to_bcd(input int v);
        to_bcd = {4'(v / 1000), 4'((v / 100) % 10),
                  4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic push(input string n, input logic [1:0] st,
                        input logic [15:0] sc, input logic [2:0] sp);
        nq.push_back(n);
        sq.push_back(st);
        cq.push_back(sc);
        pq.push_back(sp);
    endtask

    task automatic push_model(input string n);
        push(n, m_st, to_bcd(m_score), 3'(m_speed));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        string       n;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [2:0]  sp;
        while (nq.size() > 0) begin
            n  = nq.pop_front();
            st = sq.pop_front();
            sc = cq.pop_front();
            sp = pq.pop_front();
            total++;
            if (io.state !== st || io.score_bcd !== sc ||
                io.speed_level !== sp ||
                io.game_run !== (st == S_RUN) ||
                io.game_over !== (st == S_DEAD) ||
                io.clr_world !== (st == S_CLEAR)) begin
                bad++;
                $display("FAIL %s: got st=%0d sc=%h sp=%0d run=%b over=%b clr=%b want st=%0d sc=%h sp=%0d",
                         n, io.state, io.score_bcd, io.speed_level,
                         io.game_run, io.game_over, io.clr_world,
                         st, sc, sp);
            end
        end
    end

    // mode 0 clean, 1 hit mid-frame, 2 crash with rdn high,
    // 3 hit only in the frame_tick cycle
    task automatic frame(input int mode, input string n);
        for (int c = 0; c < 3; c++) begin
            io.frame_tick = (c == 2);
            io.pix_crash  = (mode == 1 && c == 0) || (mode == 2) ||
                            (mode == 3 && c == 2);
            io.rdn        = !((mode == 1 && c == 0) ||
                              (mode == 3 && c == 2));
            tick();
        end
        io.frame_tick = 1'b0;
        io.pix_crash  = 1'b0;
        io.rdn        = 1'b1;
        if (m_st == S_RUN) begin
            if (m_grace < 2) begin
                m_grace++;
            end else if (mode == 1 || mode == 3) begin
                m_st = S_DEAD;
            end else if (m_score < 9999) begin
                m_score++;
                if (m_score % 100 == 0 && m_speed < 7) m_speed++;
            end
        end
        push_model(n);
    endtask

    task automatic model_clear();
        m_st    = S_CLEAR;
        m_score = 0;
        m_speed = 0;
        m_grace = 0;
    endtask

    initial begin
        rst           = 1'b1;
        io.start      = 1'b0;
        io.frame_tick = 1'b0;
        io.pix_crash  = 1'b0;
        io.rdn        = 1'b1;
        m_st    = S_IDLE;
        m_score = 0;
        m_speed = 0;
        m_grace = 0;
        tick();
        tick();
        rst = 1'b0;
        push("reset", S_IDLE, 16'h0000, 3'd0);

        io.start = 1'b1;
        tick();
        model_clear();
        push("start_clear", S_CLEAR, 16'h0000, 3'd0);
        io.start = 1'b0;
        tick();
        m_st = S_RUN;
        push("start_run", S_RUN, 16'h0000, 3'd0);
        tick();
        push("clr_one_cycle", S_RUN, 16'h0000, 3'd0);

        for (int f = 0; f < 105; f++) frame(0, "clean");
        push("frames105", S_RUN, 16'h0103, 3'd1);

        frame(1, "hit_dead");
        push("dead_frozen", S_DEAD, 16'h0103, 3'd1);

        io.start = 1'b1;
        tick();
        model_clear();
        push_model("restart_clear");
        io.start = 1'b0;
        tick();
        m_st = S_RUN;
        push_model("restart_run");
        frame(1, "grace_hit");
        push("grace_ignored", S_RUN, 16'h0000, 3'd0);
        frame(0, "f2");
        frame(0, "f3");
        frame(0, "f4");
        frame(1, "f5_hit");
        push("f5_dead", S_DEAD, 16'h0002, 3'd0);

        io.start = 1'b1;
        tick();
        model_clear();
        push_model("held_clear");
        tick();
        m_st = S_RUN;
        push_model("held_run");
        tick();
        push_model("held_run2");
        io.start = 1'b0;
        tick();
        push_model("held_release");
        frame(0, "g1");
        frame(0, "g2");
        frame(2, "rdn_high");
        push("rdn_high_alive", S_RUN, 16'h0001, 3'd0);
        frame(3, "tick_hit");
        push("tick_hit_dead", S_DEAD, 16'h0001, 3'd0);

        io.start = 1'b1;
        tick();
        model_clear();
        push("repress_clear", S_CLEAR, 16'h0000, 3'd0);
        io.start = 1'b0;
        tick();
        m_st = S_RUN;
        push_model("repress_run");
        io.start = 1'b1;
        tick();
        push("run_edge_ignored", S_RUN, 16'h0000, 3'd0);
        io.start = 1'b0;

        for (int f = 0; f < 10004; f++) frame(0, "long");
        push("sat9999", S_RUN, 16'h9999, 3'd7);

        io.start      = 1'b1;
        io.pix_crash  = 1'b1;
        io.rdn        = 1'b0;
        io.frame_tick = 1'b1;
        rst           = 1'b1;
        tick();
        push("rst_mid_run", S_IDLE, 16'h0000, 3'd0);
        rst           = 1'b0;
        io.pix_crash  = 1'b0;
        io.rdn        = 1'b1;
        io.frame_tick = 1'b0;
        tick();
        push("no_spurious_edge", S_IDLE, 16'h0000, 3'd0);
        io.start = 1'b0;
        tick();
        push("idle_release", S_IDLE, 16'h0000, 3'd0);
        io.start = 1'b1;
        tick();
        push("post_rst_clear", S_CLEAR, 16'h0000, 3'd0);
        io.start = 1'b0;

        @(negedge clk);
        #1;
        if (nq.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d want 0", nq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
